// File: rtl/amm_mem_slave_if.sv
// Avalon-MM bus bundle for amm_mem_slave: one pipelined read port and one
// write port with byte enables. Suffixes _i/_o are from the slave's view.
interface amm_mem_slave_if #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 10,
    parameter int BYTE_CNT   = DATA_WIDTH / 8
);
    // read port
    logic [ADDR_WIDTH-1:0] amm_rd_address_i;
    logic                  amm_rd_read_i;
    logic [DATA_WIDTH-1:0] amm_rd_readdata_o;
    logic                  amm_rd_readdatavalid_o;
    logic                  amm_rd_waitrequest_o;

    // write port
    logic [ADDR_WIDTH-1:0] amm_wr_address_i;
    logic                  amm_wr_write_i;
    logic [DATA_WIDTH-1:0] amm_wr_writedata_i;
    logic [BYTE_CNT-1:0]   amm_wr_byteenable_i;
    logic                  amm_wr_waitrequest_o;

    modport master (
        output amm_rd_address_i,
        output amm_rd_read_i,
        input  amm_rd_readdata_o,
        input  amm_rd_readdatavalid_o,
        input  amm_rd_waitrequest_o,
        output amm_wr_address_i,
        output amm_wr_write_i,
        output amm_wr_writedata_i,
        output amm_wr_byteenable_i,
        input  amm_wr_waitrequest_o
    );

    modport slave (
        input  amm_rd_address_i,
        input  amm_rd_read_i,
        output amm_rd_readdata_o,
        output amm_rd_readdatavalid_o,
        output amm_rd_waitrequest_o,
        input  amm_wr_address_i,
        input  amm_wr_write_i,
        input  amm_wr_writedata_i,
        input  amm_wr_byteenable_i,
        output amm_wr_waitrequest_o
    );
endinterface

// File: rtl/amm_mem_slave.sv
// Avalon-MM slave memory model: shared word array behind an independent
// pipelined read port and a byte-enabled write port, with parameterised
// waitrequest stall length per port and parameterised read latency.
// Ports: clk_i, srst_i (sync, active high), amm (slave modport of
// amm_mem_slave_if carrying both the read and the write port).
module amm_mem_slave #(
    parameter int DATA_WIDTH     = 64,
    parameter int ADDR_WIDTH     = 10,
    parameter int BYTE_CNT       = DATA_WIDTH / 8,
    parameter int READ_LATENCY   = 2,
    parameter int RD_WAIT_CYCLES = 1,
    parameter int WR_WAIT_CYCLES = 2
) (
    input  logic            clk_i,
    input  logic            srst_i,
    amm_mem_slave_if.slave  amm
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [3:0] RD_N = 4'(RD_WAIT_CYCLES);
    localparam logic [3:0] WR_N = 4'(WR_WAIT_CYCLES);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [3:0] rd_cnt_q;
    logic [3:0] rd_cnt_d;
    logic [3:0] wr_cnt_q;
    logic [3:0] wr_cnt_d;

    logic rd_wait;
    logic wr_wait;
    logic rd_acc;
    logic wr_acc;

    logic [READ_LATENCY-1:0] vld_q;
    logic [READ_LATENCY-1:0] vld_d;
    logic [DATA_WIDTH-1:0]   dat_q [READ_LATENCY];
    logic [DATA_WIDTH-1:0]   dat_d [READ_LATENCY];

    // Stall generation: a request is held off until its counter reaches N,
    // so every transfer sees exactly N waitrequest cycles.
    always_comb begin
        rd_wait = amm.amm_rd_read_i && (rd_cnt_q != RD_N);
        wr_wait = amm.amm_wr_write_i && (wr_cnt_q != WR_N);
        rd_acc  = amm.amm_rd_read_i && !rd_wait;
        wr_acc  = amm.amm_wr_write_i && !wr_wait;

        rd_cnt_d = 4'd0;
        if (amm.amm_rd_read_i && rd_wait) begin
            rd_cnt_d = rd_cnt_q + 4'd1;
        end

        wr_cnt_d = 4'd0;
        if (amm.amm_wr_write_i && wr_wait) begin
            wr_cnt_d = wr_cnt_q + 4'd1;
        end
    end

    assign amm.amm_rd_waitrequest_o = rd_wait;
    assign amm.amm_wr_waitrequest_o = wr_wait;

    // Read pipeline. Stage 0 captures the memory word on accept; later
    // stages only load when a valid beat moves in, so the last stage keeps
    // presenting the most recently returned word while valid is low.
    // The read samples mem before this edge's write lands: read-before-write.
    always_comb begin
        vld_d    = '0;
        vld_d[0] = rd_acc;
        for (int k = 0; k < READ_LATENCY; k++) begin
            dat_d[k] = dat_q[k];
        end
        if (rd_acc) begin
            dat_d[0] = mem[amm.amm_rd_address_i];
        end
        for (int k = 1; k < READ_LATENCY; k++) begin
            vld_d[k] = vld_q[k-1];
            if (vld_q[k-1]) begin
                dat_d[k] = dat_q[k-1];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            rd_cnt_q <= 4'd0;
            wr_cnt_q <= 4'd0;
            vld_q    <= '0;
            for (int k = 0; k < READ_LATENCY; k++) begin
                dat_q[k] <= '0;
            end
        end else begin
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
            vld_q    <= vld_d;
            for (int k = 0; k < READ_LATENCY; k++) begin
                dat_q[k] <= dat_d[k];
            end
        end
    end

    // Memory contents are deliberately not touched by reset.
    always_ff @(posedge clk_i) begin
        if (wr_acc) begin
            for (int b = 0; b < BYTE_CNT; b++) begin
                if (amm.amm_wr_byteenable_i[b]) begin
                    mem[amm.amm_wr_address_i][8*b +: 8] <=
                        amm.amm_wr_writedata_i[8*b +: 8];
                end
            end
        end
    end

    assign amm.amm_rd_readdatavalid_o = vld_q[READ_LATENCY-1];
    assign amm.amm_rd_readdata_o      = dat_q[READ_LATENCY-1];

endmodule

// File: tb/tb_amm_mem_slave.sv
// Bench for amm_mem_slave: two instances (default timing, and zero read
// wait with latency 3) driven by shared stimulus, checked against a model.
module tb_amm_mem_slave;

    localparam int DW = 64;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          srst = 1'b1;
    logic          rd = 1'b0;
    logic [AW-1:0] raddr = '0;
    logic          wr = 1'b0;
    logic [AW-1:0] waddr = '0;
    logic [DW-1:0] wdata = '0;
    logic [7:0]    be = '0;

    amm_mem_slave_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) b0 ();
    amm_mem_slave_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) b1 ();

    assign b0.amm_rd_address_i    = raddr;
    assign b0.amm_rd_read_i       = rd;
    assign b0.amm_wr_address_i    = waddr;
    assign b0.amm_wr_write_i      = wr;
    assign b0.amm_wr_writedata_i  = wdata;
    assign b0.amm_wr_byteenable_i = be;
    assign b1.amm_rd_address_i    = raddr;
    assign b1.amm_rd_read_i       = rd;
    assign b1.amm_wr_address_i    = waddr;
    assign b1.amm_wr_write_i      = wr;
    assign b1.amm_wr_writedata_i  = wdata;
    assign b1.amm_wr_byteenable_i = be;

    amm_mem_slave #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(2),
        .RD_WAIT_CYCLES(1), .WR_WAIT_CYCLES(2)
    ) dut0 (.clk_i(clk), .srst_i(srst), .amm(b0));

    amm_mem_slave #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(3),
        .RD_WAIT_CYCLES(0), .WR_WAIT_CYCLES(2)
    ) dut1 (.clk_i(clk), .srst_i(srst), .amm(b1));

    always #5 clk = ~clk;

    logic          w_rd [2];
    logic          w_wr [2];
    logic          dv   [2];
    logic [DW-1:0] rdat [2];

    assign w_rd[0] = b0.amm_rd_waitrequest_o;
    assign w_rd[1] = b1.amm_rd_waitrequest_o;
    assign w_wr[0] = b0.amm_wr_waitrequest_o;
    assign w_wr[1] = b1.amm_wr_waitrequest_o;
    assign dv[0]   = b0.amm_rd_readdatavalid_o;
    assign dv[1]   = b1.amm_rd_readdatavalid_o;
    assign rdat[0] = b0.amm_rd_readdata_o;
    assign rdat[1] = b1.amm_rd_readdata_o;

    typedef struct {
        int            c;
        logic [DW-1:0] d;
    } resp_t;

    // model: expected responses (due cycle, word) and observed log
    resp_t rq [2][$];
    resp_t lg [2][$];
    int    n_rd [2] = '{1, 0};
    int    n_wr [2] = '{2, 2};
    int    lat  [2] = '{2, 3};
    int    seen_rd [2] = '{0, 0};
    int    seen_wr [2] = '{0, 0};
    logic [DW-1:0] last [2] = '{64'd0, 64'd0};
    logic [DW-1:0] mm [2][1024];

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    task automatic chk(input string name, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Per-cycle compare: each port stalls N cycles per transfer, each
    // accepted read returns mem (pre-write) exactly latency cycles later.
    initial forever begin
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            logic ew_r;
            logic ew_w;
            logic ev;
            logic [DW-1:0] ed;
            resp_t r;
            ew_r = rd && (seen_rd[d] < n_rd[d]);
            ew_w = wr && (seen_wr[d] < n_wr[d]);
            chk($sformatf("rd_wait%0d", d), 64'(w_rd[d]), 64'(ew_r));
            chk($sformatf("wr_wait%0d", d), 64'(w_wr[d]), 64'(ew_w));
            ev = 1'b0;
            if (rq[d].size() > 0) ev = (rq[d][0].c == cyc);
            chk($sformatf("rvalid%0d", d), 64'(dv[d]), 64'(ev));
            if (ev) begin
                r = rq[d].pop_front();
                ed = r.d;
                last[d] = ed;
            end else begin
                ed = last[d];
            end
            chk($sformatf("rdata%0d", d), rdat[d], ed);
            if (dv[d]) begin
                r.c = cyc;
                r.d = rdat[d];
                lg[d].push_back(r);
            end
            if (rd && !ew_r) begin
                if (!srst) begin
                    r.c = cyc + lat[d];
                    r.d = mm[d][raddr];
                    rq[d].push_back(r);
                end
                seen_rd[d] = 0;
            end else if (rd) begin
                seen_rd[d]++;
            end else begin
                seen_rd[d] = 0;
            end
            if (wr && !ew_w) begin
                for (int b = 0; b < 8; b++) begin
                    if (be[b]) mm[d][waddr][8*b +: 8] = wdata[8*b +: 8];
                end
                seen_wr[d] = 0;
            end else if (wr) begin
                seen_wr[d]++;
            end else begin
                seen_wr[d] = 0;
            end
            if (srst) begin
                rq[d].delete();
                seen_rd[d] = 0;
                seen_wr[d] = 0;
                last[d] = '0;
            end
        end
    end

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] dd,
                            input logic [7:0] e, output int st);
        @(posedge clk);
        #1;
        wr = 1'b1;
        waddr = a;
        wdata = dd;
        be = e;
        st = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (!w_wr[0]) break;
            st++;
        end
        @(posedge clk);
        #1;
        wr = 1'b0;
    endtask

    task automatic do_read(input logic [AW-1:0] a, output logic [DW-1:0] dd,
                           output int l, output int st);
        int ac;
        @(posedge clk);
        #1;
        lg[0].delete();
        rd = 1'b1;
        raddr = a;
        st = 0;
        ac = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            ac = cyc;
            if (!w_rd[0]) break;
            st++;
        end
        @(posedge clk);
        #1;
        rd = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (lg[0].size() > 0) break;
            @(posedge clk);
        end
        if (lg[0].size() == 0) begin
            dd = '0;
            l = -1;
        end else begin
            dd = lg[0][0].d;
            l = lg[0][0].c - ac;
        end
    endtask

    // dut1 streams 4 reads back to back (0x3FC..0x3FF); optionally a
    // write is held on the other port at the same time.
    task automatic stream(input string tag, input bit with_wr);
        int s;
        @(posedge clk);
        #1;
        lg[1].delete();
        rd = 1'b1;
        if (with_wr) begin
            wr = 1'b1;
            waddr = 10'h022;
            wdata = {$urandom, $urandom};
            be = 8'hFF;
        end
        s = 0;
        for (int i = 0; i < 4; i++) begin
            raddr = 10'h3FC + 10'(i);
            @(negedge clk);
            if (i == 0) s = cyc;
            chk({tag, "_nowait"}, 64'(w_rd[1]), 64'd0);
            @(posedge clk);
            #1;
        end
        rd = 1'b0;
        wr = 1'b0;
        repeat (8) @(posedge clk);
        chk({tag, "_count"}, 64'(lg[1].size()), 64'd4);
        for (int i = 0; i < 4 && i < lg[1].size(); i++) begin
            chk({tag, "_cyc"}, 64'(lg[1][i].c), 64'(s + 3 + i));
            chk({tag, "_data"}, lg[1][i].d, 64'(i + 1));
        end
    endtask

    logic [AW-1:0] pick [8] = '{10'h000, 10'h005, 10'h010, 10'h020,
                                10'h3FC, 10'h3FD, 10'h3FE, 10'h3FF};

    initial begin
        int st;
        int l;
        logic [DW-1:0] d;

        repeat (3) @(posedge clk);
        #1;
        srst = 1'b0;
        @(negedge clk);
        chk("rst_valid0", 64'(dv[0]), 64'd0);
        chk("rst_data0", rdat[0], 64'd0);
        chk("rst_valid1", 64'(dv[1]), 64'd0);
        chk("rst_data1", rdat[1], 64'd0);

        do_write(10'h010, 64'h1122334455667788, 8'hFF, st);
        chk("wr_stall", 64'(st), 64'd2);
        do_read(10'h010, d, l, st);
        chk("rd_stall", 64'(st), 64'd1);
        chk("rd_lat", 64'(l), 64'd2);
        chk("rd_data", d, 64'h1122334455667788);

        do_write(10'h020, 64'hFFFFFFFFFFFFFFFF, 8'hFF, st);
        do_write(10'h020, 64'h0, 8'h0F, st);
        do_read(10'h020, d, l, st);
        chk("be_0f", d, 64'hFFFFFFFF00000000);
        do_write(10'h020, 64'h1234, 8'h00, st);
        chk("be_00_stall", 64'(st), 64'd2);
        do_read(10'h020, d, l, st);
        chk("be_00", d, 64'hFFFFFFFF00000000);

        do_write(10'h3FC, 64'd1, 8'hFF, st);
        do_write(10'h3FD, 64'd2, 8'hFF, st);
        do_write(10'h3FE, 64'd3, 8'hFF, st);
        do_write(10'h3FF, 64'd4, 8'hFF, st);
        do_write(10'h005, 64'hAA, 8'hFF, st);
        do_write(10'h000, 64'h0, 8'hFF, st);

        stream("stream", 1'b0);

        // collision on dut0: write starts one cycle before the read,
        // so both are accepted in the same cycle
        @(posedge clk);
        #1;
        lg[0].delete();
        wr = 1'b1;
        waddr = 10'h005;
        wdata = 64'hBB;
        be = 8'hFF;
        @(posedge clk);
        #1;
        rd = 1'b1;
        raddr = 10'h005;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("col_wr_acc", 64'(w_wr[0]), 64'd0);
        chk("col_rd_acc", 64'(w_rd[0]), 64'd0);
        @(posedge clk);
        #1;
        wr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rd = 1'b0;
        repeat (6) @(posedge clk);
        chk("col_count", 64'(lg[0].size()), 64'd2);
        if (lg[0].size() == 2) begin
            chk("col_old", lg[0][0].d, 64'hAA);
            chk("col_new", lg[0][1].d, 64'hBB);
        end

        // reset one cycle after a read accept: response must be dropped
        @(posedge clk);
        #1;
        lg[0].delete();
        rd = 1'b1;
        raddr = 10'h010;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (!w_rd[0]) break;
        end
        @(posedge clk);
        #1;
        rd = 1'b0;
        srst = 1'b1;
        @(posedge clk);
        #1;
        srst = 1'b0;
        repeat (6) @(posedge clk);
        chk("rst_drop", 64'(lg[0].size()), 64'd0);
        do_write(10'h021, 64'h5555, 8'hFF, st);
        chk("rst_wr_stall", 64'(st), 64'd2);
        do_read(10'h010, d, l, st);
        chk("rst_mem_kept", d, 64'h1122334455667788);

        stream("indep", 1'b1);

        for (int n = 0; n < 800; n++) begin
            @(posedge clk);
            #1;
            rd = ($urandom_range(0, 9) < 6);
            raddr = pick[$urandom_range(0, 7)];
            wr = ($urandom_range(0, 9) < 5);
            waddr = pick[$urandom_range(0, 7)];
            wdata = {$urandom, $urandom};
            be = 8'($urandom);
            srst = ($urandom_range(0, 49) == 0);
        end
        @(posedge clk);
        #1;
        rd = 1'b0;
        wr = 1'b0;
        srst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
